// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types, FSM states and update arithmetic for the STDP scheduler
package stdp_pkg;

  localparam int DEF_TIMER_W  = 4;
  localparam int DEF_WEIGHT_W = 4;

  typedef logic [DEF_TIMER_W-1:0]  timer_t;
  typedef logic [DEF_WEIGHT_W-1:0] weight_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_APPLY = 2'd2
  } sched_state_t;

  // Close pairings (dt below half the window) get a double step.
  function automatic int step_delta(input int dt, input int window, input int step);
    return (dt < window / 2) ? 2 * step : step;
  endfunction

  function automatic int sat_apply(input int w, input int delta, input logic ltp, input int w_max);
    int r;
    r = ltp ? (w + delta) : (w - delta);
    if (r > w_max) r = w_max;
    else if (r < 0) r = 0;
    return r;
  endfunction

endpackage

// File: rtl/stdp_rr_arbiter.sv
// rtl/stdp_rr_arbiter.sv - combinational round-robin pick starting at ptr
module stdp_rr_arbiter
  import stdp_pkg::*;
#(
  parameter int NUM_PRE = 4,
  parameter int IDX_W   = $clog2(NUM_PRE)
) (
  input  logic [NUM_PRE-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_PRE-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  // NUM_PRE is a power of two, so the index add wraps naturally.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = ptr;
    for (int k = 0; k < NUM_PRE; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/stdp_update_sched.sv
// rtl/stdp_update_sched.sv - spike-timing tracker, LTP/LTD request queue and shared weight RMW engine
module stdp_update_sched
  import stdp_pkg::*;
#(
  parameter int NUM_PRE  = 4,
  parameter int TIMER_W  = $bits(timer_t),
  parameter int WEIGHT_W = $bits(weight_t),
  parameter int WINDOW   = 8,
  parameter int STEP     = 1,
  parameter int INIT_W   = 8,
  localparam int IDX_W   = $clog2(NUM_PRE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_PRE-1:0]            pre_spike,
  input  logic                          post_spike,
  output logic                          upd_valid,
  output logic [IDX_W-1:0]              upd_idx,
  output logic                          upd_ltp,
  output logic [TIMER_W-1:0]            upd_dt,
  output logic [NUM_PRE*WEIGHT_W-1:0]   weight_flat,
  output logic                          busy,
  output logic                          overflow
);

  localparam logic [TIMER_W-1:0] T_MAX = '1;
  localparam logic [TIMER_W-1:0] WIN_T = TIMER_W'(WINDOW);
  localparam int                 W_MAX = (1 << WEIGHT_W) - 1;

  logic [TIMER_W-1:0]  pre_timer [NUM_PRE];
  logic [TIMER_W-1:0]  pre_age   [NUM_PRE];
  logic [TIMER_W-1:0]  ltp_dt    [NUM_PRE];
  logic [TIMER_W-1:0]  ltd_dt    [NUM_PRE];
  logic [WEIGHT_W-1:0] weight    [NUM_PRE];
  logic [TIMER_W-1:0]  post_timer, post_age;
  logic [NUM_PRE-1:0]  ltp_pend, ltd_pend, ltp_set, ltd_set, ltp_clr, ltd_clr;
  logic [NUM_PRE-1:0]  req, gnt;
  logic [IDX_W-1:0]    ptr, gnt_idx, cur_idx;
  logic                cur_ltp, load_ltp, do_load;
  logic [TIMER_W-1:0]  cur_dt;
  logic [WEIGHT_W-1:0] new_w;
  sched_state_t        state, state_nxt;

  // dt counts edges since the spike, so pairing uses the advanced (not yet cleared) timer value.
  always_comb begin
    post_age = (post_timer == T_MAX) ? T_MAX : post_timer + TIMER_W'(1);
    for (int i = 0; i < NUM_PRE; i++) begin
      pre_age[i] = (pre_timer[i] == T_MAX) ? T_MAX : pre_timer[i] + TIMER_W'(1);
      ltp_set[i] = en && post_spike && (pre_spike[i] || (pre_age[i] < WIN_T));
      ltd_set[i] = en && pre_spike[i] && !post_spike && (post_age < WIN_T);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_timer <= T_MAX;
      for (int i = 0; i < NUM_PRE; i++) pre_timer[i] <= T_MAX;
    end else begin
      post_timer <= post_spike ? '0 : post_age;
      for (int i = 0; i < NUM_PRE; i++) pre_timer[i] <= pre_spike[i] ? '0 : pre_age[i];
    end
  end

  assign req      = ltp_pend | ltd_pend;
  assign do_load  = (state == ST_LOAD) && (|req);
  assign load_ltp = ltp_pend[gnt_idx];

  stdp_rr_arbiter #(
    .NUM_PRE (NUM_PRE),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    ltp_clr = '0;
    ltd_clr = '0;
    if (do_load) begin
      if (load_ltp) ltp_clr = gnt;
      else          ltd_clr = gnt;
    end
  end

  // A same-cycle set beats the scheduler's clear and is not an overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ltp_pend <= '0;
      ltd_pend <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM_PRE; i++) begin
        ltp_dt[i] <= '0;
        ltd_dt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PRE; i++) begin
        if (ltp_set[i]) begin
          ltp_pend[i] <= 1'b1;
          ltp_dt[i]   <= pre_spike[i] ? '0 : pre_age[i];
          if (ltp_pend[i] && !ltp_clr[i]) overflow <= 1'b1;
        end else if (ltp_clr[i]) begin
          ltp_pend[i] <= 1'b0;
        end
        if (ltd_set[i]) begin
          ltd_pend[i] <= 1'b1;
          ltd_dt[i]   <= post_age;
          if (ltd_pend[i] && !ltd_clr[i]) overflow <= 1'b1;
        end else if (ltd_clr[i]) begin
          ltd_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (|req) ? ST_APPLY : ST_IDLE;
      ST_APPLY: state_nxt = (|req) ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign new_w = WEIGHT_W'(sat_apply(int'(weight[cur_idx]),
                                     step_delta(int'(cur_dt), WINDOW, STEP),
                                     cur_ltp, W_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx <= '0;
      cur_ltp <= 1'b0;
      cur_dt  <= '0;
      ptr     <= '0;
      for (int i = 0; i < NUM_PRE; i++) weight[i] <= WEIGHT_W'(INIT_W);
    end else begin
      if (do_load) begin
        cur_idx <= gnt_idx;
        cur_ltp <= load_ltp;
        cur_dt  <= load_ltp ? ltp_dt[gnt_idx] : ltd_dt[gnt_idx];
      end
      if (state == ST_APPLY) begin
        weight[cur_idx] <= new_w;
        ptr             <= cur_idx + IDX_W'(1);
      end
    end
  end

  assign upd_valid = (state == ST_APPLY);
  assign upd_idx   = cur_idx;
  assign upd_ltp   = cur_ltp;
  assign upd_dt    = cur_dt;
  assign busy      = (state != ST_IDLE) || (|req);

  for (genvar g = 0; g < NUM_PRE; g++) begin : g_wflat
    assign weight_flat[g*WEIGHT_W +: WEIGHT_W] = weight[g];
  end

endmodule

// File: doc/stdp_update_sched.md
# stdp_update_sched

Scheduler and shared weight-update engine for the STDP array. Tracks spike timing for NUM_PRE presynaptic channels and one postsynaptic neuron, and queues LTP/LTD requests per channel. One read-modify-write unit serves those requests round-robin and applies saturating updates to an internal weight register file. It sits between the spike inputs and the weight outputs that downstream neuron logic consumes.

## Interface
- NUM_PRE, 4, number of presynaptic channels (power of two, ≥2)
- TIMER_W, 4, spike-timer width
- WEIGHT_W, 4, weight width
- WINDOW, 8, pairing window; |dt| < WINDOW generates a request (WINDOW ≤ 2^TIMER_W−1)
- STEP, 1, base weight step
- INIT_W, 8, reset weight value
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = accept new spike events; 0 = block new requests, drain pending ones
- pre_spike  in  NUM_PRE  presynaptic spike, one bit per channel
- post_spike  in  1  postsynaptic spike
- upd_valid  out  1  high for exactly the cycle in which an update is being applied
- upd_idx  out  log2(NUM_PRE)  channel being updated
- upd_ltp  out  1  1 = potentiation, 0 = depression
- upd_dt  out  TIMER_W  |dt| used for the update
- weight_flat  out  NUM_PRE*WEIGHT_W  weight of channel i at bits [i*WEIGHT_W +: WEIGHT_W]
- busy  out  1  FSM not IDLE, or any request pending
- overflow  out  1  sticky; set when a new event overwrites a still-pending request of the same kind

## Operation
- Timers: pre_timer[i] and post_timer saturate at 2^TIMER_W−1 and never wrap. A spike clears its timer to 0 on the sampling edge. The reset value is the saturated value, so no pairing occurs right after reset.
- All pairing uses timer values from before the clear.
- LTP request: post_spike && en. Every i with pre_timer[i] < WINDOW sets ltp_pend[i] and latches ltp_dt[i] = pre_timer[i].
- LTD request: pre_spike[i] && en && post_timer < WINDOW sets ltd_pend[i] and latches ltd_dt[i] = post_timer.
- Simultaneous pre_spike[i] and post_spike: only LTP is requested, with dt = 0. No LTD is requested for that channel.
- Overwrite: a new event of the same kind on a pending channel replaces dt and sets overflow.
- Set versus clear: if the scheduler clears a pending bit in the same cycle a new event sets it, the set wins and overflow is not flagged.
- Channel request is ltp_pend[i] | ltd_pend[i].
- Arbitration is round-robin. The search starts at ptr (reset 0), and ptr = grant+1 mod NUM_PRE after each APPLY.
- A channel with both kinds pending is served LTP first. LTD is served on that channel's next grant.
- FSM states:
  - IDLE: any request → LOAD.
  - LOAD: arbitrate; latch idx, kind and dt; clear that pend bit → APPLY.
  - APPLY: write the weight, assert upd_valid, advance ptr → LOAD if any request remains, else IDLE.
- Arithmetic: delta = 2*STEP if dt < WINDOW/2, else STEP. LTP gives min(w+delta, 2^WEIGHT_W−1). LTD gives max(w−delta, 0). Compute at WEIGHT_W+1 bits.
- en = 0 does not stop timers or the FSM.

## Timing
- Reset values: weights = INIT_W, timers saturated, pend = 0, FSM = IDLE, ptr = 0.
- Output reset values: upd_valid = 0, upd_idx = 0, upd_ltp = 0, upd_dt = 0, busy = 0, overflow = 0.
- Event sampled at edge E0 sets pend after E0. The FSM enters LOAD after E1 and APPLY after E2. upd_valid, upd_idx, upd_ltp and upd_dt are valid between E2 and E3. The new weight is visible on weight_flat after E3.
- Back-to-back throughput is one update per 2 cycles (LOAD/APPLY alternating).
- upd_idx, upd_ltp and upd_dt hold their last values outside APPLY.
- Async reset in any state, including mid-APPLY, returns everything to reset values immediately. An interrupted update is not written.

## Structure
- stdp_pkg holds:
  - timer and weight typedefs;
  - the FSM state enum;
  - the delta and saturation helper functions.
- Sub-module stdp_rr_arbiter: NUM_PRE-bit request vector plus ptr in, one-hot grant and encoded index out. It is purely combinational; ptr is owned by the scheduler.

## Test plan
- Reset check: after rst, weight_flat = all channels 8, busy = 0, overflow = 0. post_spike alone → no upd_valid.
- LTP near: pre_spike[1] at E0, post_spike at E3 (dt = 3) → one upd_valid with idx 1, ltp = 1, dt = 3. Weight[1] becomes 10.
- LTD far: post_spike, then pre_spike[2] 5 cycles later → upd_valid with idx 2, ltp = 0, dt = 5. Weight[2] becomes 7.
- Window edge: pre_spike[0] and post_spike 8 cycles apart → no update. Repeat at 7 cycles → weight[0] becomes 9.
- Simultaneous and round-robin: pre_spike = 4'b1111 and post_spike in the same cycle → four LTP updates with dt = 0, idx 0,1,2,3, upd_valid every 2nd cycle. All weights become 10.
- Saturation, overflow and reset: repeat LTP on channel 3 until it holds at 15. Two post_spikes 1 cycle apart while the FSM is busy → overflow = 1. Assert rst during APPLY → no write; weights and overflow return to reset values.
